// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store unit. Issues data-memory requests over a
//            req/gnt/rvalid handshake, builds byte enables and store-lane
//            replication, and sign/zero-extends load data. It holds the
//            pipeline stall high until the access completes or times out.
// Options  : MISALIGN_TRAP_EN - adds a misalign output. A misaligned half or
//            word access then completes locally as a trap and is not issued
//            to memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  readdatasel,
    input  logic [1:0]  writedatasel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    // The counter must be able to hold TIMEOUT_CYCLES. A load granted on the
    // timeout edge steps it one past the last value.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_rsel;
    logic [1:0]         r_off;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_issue;
    logic               w_timeout;
    logic [3:0]         w_store_be;
    logic [31:0]        w_store_wdata;
    logic [7:0]         w_lane_byte;
    logic [15:0]        w_lane_half;
    logic [31:0]        w_load_data;

    assign req_ready = (r_state == S_IDLE);
    assign stall     = (r_state != S_IDLE);
    assign w_accept  = req_valid & req_ready & (mem_read | mem_write);

`ifdef MISALIGN_TRAP_EN
    logic w_is_half;
    logic w_is_word;
    logic w_misaligned;
    logic w_trap;

    // Classify access size; store selection wins when both read and write are set
    always_comb begin
        w_is_half = 1'b0;
        w_is_word = 1'b0;
        if (mem_write) begin
            w_is_half = (writedatasel == 2'b10);
            w_is_word = (writedatasel == 2'b00) || (writedatasel == 2'b11);
        end else begin
            w_is_half = (readdatasel == 3'b010) || (readdatasel == 3'b100);
            w_is_word = !((readdatasel == 3'b001) || (readdatasel == 3'b011) || w_is_half);
        end
    end

    assign w_misaligned = (w_is_half & addr[0]) | (w_is_word & (addr[1:0] != 2'b00));
    assign w_issue      = w_accept & ~w_misaligned;
    assign w_trap       = w_accept &  w_misaligned;
`else
    assign w_issue      = w_accept;
`endif

    // The timeout is off when TIMEOUT_CYCLES is 0. Otherwise it fires on the
    // TIMEOUT_CYCLES-th edge after the accept edge.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt >= CNT_LAST);

    // Store byte enables and lane replication from writedatasel and addr
    always_comb begin
        w_store_be    = 4'b1111;
        w_store_wdata = wdata;
        case (writedatasel)
            2'b01: begin
                w_store_be    = 4'b0001 << addr[1:0];
                w_store_wdata = {4{wdata[7:0]}};
            end
            2'b10: begin
                w_store_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_store_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_store_be    = 4'b1111;
                w_store_wdata = wdata;
            end
        endcase
    end

    // Load lane selection and extension using the selection latched on accept
    always_comb begin
        case (r_off)
            2'd0:    w_lane_byte = dmem_rdata[7:0];
            2'd1:    w_lane_byte = dmem_rdata[15:8];
            2'd2:    w_lane_byte = dmem_rdata[23:16];
            default: w_lane_byte = dmem_rdata[31:24];
        endcase
        w_lane_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_rsel)
            3'b001:  w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b010:  w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
            3'b011:  w_load_data = {24'd0, w_lane_byte};
            3'b100:  w_load_data = {16'd0, w_lane_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // Access FSM with registered memory-side and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rsel     <= 3'd0;
            r_off      <= 2'd0;
            r_cnt      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state    <= S_REQ;
                        r_rsel     <= readdatasel;
                        r_off      <= addr[1:0];
                        r_cnt      <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= mem_write ? w_store_be : 4'b1111;
                        dmem_wdata <= mem_write ? w_store_wdata : 32'd0;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (w_trap) begin
                        resp_valid <= 1'b1;
                        misalign   <= 1'b1;
                        resp_data  <= 32'd0;
                    end
`endif
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A grant arriving on the timeout edge still counts as progress
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            r_state    <= S_IDLE;
                            resp_valid <= 1'b1;
                            resp_data  <= 32'd0;
                        end else begin
                            r_state    <= S_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_IDLE;
                        dmem_req   <= 1'b0;
                        resp_valid <= 1'b1;
                        bus_err    <= 1'b1;
                        resp_data  <= 32'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dmem_rvalid) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b1;
                        resp_data  <= w_load_data;
                    end else if (w_timeout) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b1;
                        bus_err    <= 1'b1;
                        resp_data  <= 32'd0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit. A bench-side memory
//            responder drives the unit, and a scoreboard queue holds the
//            expected responses that a monitor pops on each resp_valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  readdatasel;
    logic [1:0]  writedatasel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        mis;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    n_checks = 0;
    int    n_fails  = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .readdatasel  (readdatasel),
        .writedatasel (writedatasel),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .bus_err      (bus_err),
`ifdef MISALIGN_TRAP_EN
        .misalign     (misalign),
`endif
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] rs, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*off +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (rs)
            3'b001:  return {{24{b[7]}}, b};
            3'b010:  return {{16{h[15]}}, h};
            3'b011:  return {24'd0, b};
            3'b100:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input bit st, input logic [1:0] ws, input logic [1:0] off);
        if (!st)         return 4'b1111;
        if (ws == 2'b01) return 4'b0001 << off;
        if (ws == 2'b10) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] ws, input logic [31:0] wd);
        if (ws == 2'b01) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (ws == 2'b10) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e, input logic m);
        resp_t r;
        r.data = d;
        r.err  = e;
        r.mis  = m;
        exp_q.push_back(r);
    endtask

    task automatic drive_req(input bit st, input bit both, input logic [2:0] rs,
                             input logic [1:0] ws, input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        mem_write    = st;
        mem_read     = both | !st;
        readdatasel  = rs;
        writedatasel = ws;
        addr         = a;
        wdata        = wd;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // One access: gd cycles in REQ before gnt, rvd cycles in WAIT before rvalid
    task automatic run_access(input bit st, input bit both, input logic [2:0] rs,
                              input logic [1:0] ws, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int gd, input int rvd);
        check_value("ready_before", req_ready, 1);
        drive_req(st, both, rs, ws, a, wd);
        step();
        idle_req();
        push_exp(st ? 32'd0 : exp_load(rs, a[1:0], rd), 1'b0, 1'b0);
        for (int i = 0; i <= gd; i++) begin
            check_value("dmem_req", dmem_req, 1);
            check_value("dmem_addr", dmem_addr, {a[31:2], 2'b00});
            check_value("dmem_be", dmem_be, exp_be(st, ws, a[1:0]));
            check_value("dmem_we", dmem_we, st);
            if (st) check_value("dmem_wdata", dmem_wdata, exp_wd(ws, wd));
            check_value("stall_req", stall, 1);
            dmem_rvalid = (i < gd);
            dmem_rdata  = 32'hBAD0BAD0;
            dmem_gnt    = (i == gd);
            step();
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check_value("req_dropped", dmem_req, 0);
        if (!st) begin
            for (int i = 0; i < rvd; i++) begin
                check_value("stall_wait", stall, 1);
                check_value("no_early_resp", resp_valid, 0);
                step();
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = rd;
            step();
            dmem_rvalid = 1'b0;
        end
        check_value("resp_valid", resp_valid, 1);
        check_value("ready_after", req_ready, 1);
    endtask

    // Scoreboard monitor: every resp_valid cycle must match the next expected entry
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_resp", resp_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("resp_data", resp_data, mon_e.data);
                check_value("bus_err", bus_err, mon_e.err);
`ifdef MISALIGN_TRAP_EN
                check_value("misalign", misalign, mon_e.mis);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_req();
        readdatasel  = 3'd0;
        writedatasel = 2'd0;
        addr         = 32'd0;
        wdata        = 32'd0;
        dmem_gnt     = 1'b0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = 32'd0;
        repeat (3) step();
        check_value("rst_ready", req_ready, 1);
        check_value("rst_stall", stall, 0);
        check_value("rst_dmem_req", dmem_req, 0);
        check_value("rst_dmem_we", dmem_we, 0);
        check_value("rst_dmem_addr", dmem_addr, 0);
        check_value("rst_dmem_be", dmem_be, 0);
        check_value("rst_dmem_wdata", dmem_wdata, 0);
        check_value("rst_resp_valid", resp_valid, 0);
        check_value("rst_resp_data", resp_data, 0);
        check_value("rst_bus_err", bus_err, 0);
        reset = 1'b0;
        step();

        // req_valid with neither read nor write is not an access
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check_value("noop_stall", stall, 0);
        check_value("noop_dmem_req", dmem_req, 0);

        // Loads with every extension mode, and stores with every lane pattern
        run_access(0, 0, 3'b001, 2'b00, 32'h0000_0103, 32'd0, 32'h80AA_5511, 0, 0);
        run_access(0, 0, 3'b011, 2'b00, 32'h0000_0103, 32'd0, 32'h80AA_5511, 0, 0);
        run_access(1, 0, 3'b000, 2'b10, 32'h0000_0102, 32'h1234_ABCD, 32'd0, 0, 0);
        run_access(0, 0, 3'b000, 2'b00, 32'h0000_0204, 32'd0, 32'hDEAD_BEEF, 3, 2);
        run_access(0, 0, 3'b010, 2'b00, 32'h0000_0102, 32'd0, 32'h80AA_5511, 1, 0);
        run_access(0, 0, 3'b100, 2'b00, 32'h0000_0102, 32'd0, 32'h80AA_5511, 0, 1);
        run_access(0, 0, 3'b010, 2'b00, 32'h0000_0100, 32'd0, 32'h1234_7FFF, 0, 0);
        run_access(0, 0, 3'b001, 2'b00, 32'h0000_0300, 32'd0, 32'h0000_007F, 0, 0);
        run_access(1, 1, 3'b001, 2'b01, 32'h0000_0101, 32'h0000_0055, 32'd0, 2, 0);
        run_access(1, 0, 3'b000, 2'b11, 32'h0000_0400, 32'hCAFE_F00D, 32'd0, 0, 0);
        run_access(0, 0, 3'b111, 2'b00, 32'h0000_0500, 32'd0, 32'h8765_4321, 0, 0);
`ifndef MISALIGN_TRAP_EN
        // Low address bits are ignored when no trap is built in
        run_access(1, 0, 3'b000, 2'b00, 32'h0000_00FF, 32'h0BAD_CAFE, 32'd0, 0, 0);
        run_access(0, 0, 3'b010, 2'b00, 32'h0000_0103, 32'd0, 32'hF00D_1234, 0, 0);
`endif
        // A grant on the timeout edge completes normally
        run_access(1, 0, 3'b000, 2'b00, 32'h0000_0600, 32'h1111_2222, 32'd0, TO - 1, 0);

        // No grant: abort with bus_err exactly TO edges after the accept edge
        drive_req(0, 0, 3'b000, 2'b00, 32'h0000_0700, 32'd0);
        step();
        idle_req();
        push_exp(32'd0, 1'b1, 1'b0);
        for (int i = 0; i < TO; i++) begin
            check_value("to_req_held", dmem_req, 1);
            check_value("to_no_resp", resp_valid, 0);
            step();
        end
        check_value("to_resp_valid", resp_valid, 1);
        check_value("to_bus_err", bus_err, 1);
        check_value("to_req_drop", dmem_req, 0);
        check_value("to_stall", stall, 0);
        step();

        // Reset while in REQ drops the request at once
        drive_req(0, 0, 3'b000, 2'b00, 32'h0000_0800, 32'd0);
        step();
        idle_req();
        check_value("rreq_req", dmem_req, 1);
        reset = 1'b1;
        #1;
        check_value("rreq_req_drop", dmem_req, 0);
        check_value("rreq_ready", req_ready, 1);
        step();
        reset = 1'b0;
        step();

        // Reset while in WAIT: a late rvalid must produce no response
        drive_req(0, 0, 3'b000, 2'b00, 32'h0000_0900, 32'd0);
        step();
        idle_req();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_value("rwait_stall", stall, 1);
        reset = 1'b1;
        #1;
        check_value("rwait_stall_clr", stall, 0);
        check_value("rwait_req", dmem_req, 0);
        step();
        reset = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        step();
        dmem_rvalid = 1'b0;
        check_value("rwait_no_resp", resp_valid, 0);
        check_value("rwait_idle", req_ready, 1);

`ifdef MISALIGN_TRAP_EN
        // Misaligned half is trapped locally without a memory request
        drive_req(0, 0, 3'b010, 2'b00, 32'h0000_0101, 32'd0);
        step();
        idle_req();
        push_exp(32'd0, 1'b0, 1'b1);
        check_value("mis_no_req", dmem_req, 0);
        check_value("mis_no_stall", stall, 0);
        check_value("mis_resp", resp_valid, 1);
        check_value("mis_flag", misalign, 1);
        step();
`endif

        repeat (3) step();
        check_value("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
